// File: rtl/ndn_packet_parser_if.sv
// NDN parser bus: SPI byte input, prefix handshake,
// payload FIFO head and status outputs.
interface ndn_packet_parser_if #(
  parameter int PREFIX_W = 64,
  parameter int LEN_W    = 6
);
  logic [7:0]          rx_byte;
  logic                rx_valid;
  logic                cs;
  logic [PREFIX_W-1:0] prefix;
  logic [LEN_W-1:0]    length;
  logic                interest_packet;
  logic                prefix_valid;
  logic                prefix_ready;
  logic [7:0]          pay_data;
  logic                pay_valid;
  logic                pay_ready;
  logic                err;
  logic [2:0]          err_code;
  logic [15:0]         pkt_count;

  modport master (
    output rx_byte, rx_valid, cs,
    output prefix_ready, pay_ready,
    input  prefix, length, interest_packet,
    input  prefix_valid, pay_data, pay_valid,
    input  err, err_code, pkt_count
  );

  modport slave (
    input  rx_byte, rx_valid, cs,
    input  prefix_ready, pay_ready,
    output prefix, length, interest_packet,
    output prefix_valid, pay_data, pay_valid,
    output err, err_code, pkt_count
  );
endinterface

// File: rtl/ndn_packet_parser.sv
// NDN packet framer: type, length, prefix extraction
// with a first-word-fall-through payload FIFO.
module ndn_packet_parser #(
  parameter int PREFIX_W   = 64,
  parameter int LEN_W      = 6,
  parameter int FIFO_DEPTH = 16
) (
  input logic clk,
  input logic rst,
  ndn_packet_parser_if.slave bus
);
  localparam int PB = PREFIX_W / 8;
  localparam int CW = $clog2(PB) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, LEN, PREFIX, PAYLOAD, HOLD, DISCARD
  } state_t;

  state_t st, nxt;

  logic [PREFIX_W-1:0] sh_q, pfx_q, sh_nx;
  logic [LEN_W-1:0]    len_r, len_q, rem_q;
  logic [CW-1:0]       pcnt_q;
  logic                type_r, ip_q;
  logic                pv_q, hs_done;
  logic                err_q;
  logic [2:0]          code_q;
  logic [15:0]         pkt_q;

  logic [7:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [AW:0]         cnt_q;

  logic take, pop, full, hs;
  logic err_set, push, load, done;
  logic lat_type, lat_len, shift;
  logic [2:0] err_nc;

  assign take  = bus.rx_valid && !bus.cs;
  assign pop   = bus.pay_ready && (cnt_q != '0);
  assign full  = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign hs    = pv_q && bus.prefix_ready;
  assign sh_nx = PREFIX_W'({sh_q, bus.rx_byte});

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= nxt;
  end

  // Next-state and per-cycle control decode
  always_comb begin
    nxt      = st;
    err_set  = 1'b0;
    err_nc   = 3'd0;
    push     = 1'b0;
    load     = 1'b0;
    done     = 1'b0;
    lat_type = 1'b0;
    lat_len  = 1'b0;
    shift    = 1'b0;
    unique case (st)
      IDLE: if (take) begin
        if (bus.rx_byte == 8'h05 ||
            bus.rx_byte == 8'h06) begin
          lat_type = 1'b1;
          nxt      = LEN;
        end else begin
          err_set = 1'b1;
          err_nc  = 3'd1;
          nxt     = DISCARD;
        end
      end
      LEN: if (take) begin
        if ((bus.rx_byte >> LEN_W) != 8'd0) begin
          err_set = 1'b1;
          err_nc  = 3'd2;
          nxt     = DISCARD;
        end else begin
          lat_len = 1'b1;
          nxt     = PREFIX;
        end
      end else if (bus.cs) begin
        err_set = 1'b1;
        err_nc  = 3'd3;
        nxt     = IDLE;
      end
      PREFIX: if (take) begin
        shift = 1'b1;
        if (pcnt_q == CW'(PB - 1)) begin
          load = 1'b1;
          nxt  = (len_r == '0) ? HOLD : PAYLOAD;
        end
      end else if (bus.cs) begin
        err_set = 1'b1;
        err_nc  = 3'd3;
        nxt     = IDLE;
      end
      PAYLOAD: if (take) begin
        if (full && !pop) begin
          err_set = 1'b1;
          err_nc  = 3'd5;
          nxt     = DISCARD;
        end else begin
          push = 1'b1;
          if (rem_q == LEN_W'(1)) nxt = HOLD;
        end
      end else if (bus.cs) begin
        err_set = 1'b1;
        err_nc  = 3'd3;
        nxt     = IDLE;
      end
      HOLD: if (hs_done || hs) begin
        done = 1'b1;
        nxt  = IDLE;
      end else if (take) begin
        err_set = 1'b1;
        err_nc  = 3'd4;
      end
      DISCARD: if (bus.cs) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Frame header, prefix capture and handshake tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q    <= '0;
      pfx_q   <= '0;
      len_r   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      pcnt_q  <= '0;
      type_r  <= 1'b0;
      ip_q    <= 1'b0;
      pv_q    <= 1'b0;
      hs_done <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
      pkt_q   <= 16'd0;
    end else begin
      err_q <= err_set;
      if (err_set) code_q <= err_nc;
      if (lat_type) type_r <= bus.rx_byte == 8'h05;
      if (lat_len) begin
        len_r  <= bus.rx_byte[LEN_W-1:0];
        rem_q  <= bus.rx_byte[LEN_W-1:0];
        pcnt_q <= '0;
      end
      if (shift) begin
        sh_q   <= sh_nx;
        pcnt_q <= pcnt_q + CW'(1);
      end
      if (push) rem_q <= rem_q - LEN_W'(1);
      if (load) begin
        pfx_q   <= sh_nx;
        len_q   <= len_r;
        ip_q    <= type_r;
        pv_q    <= 1'b1;
        hs_done <= 1'b0;
      end else if (hs) begin
        pv_q    <= 1'b0;
        hs_done <= 1'b1;
      end
      if (done) pkt_q <= pkt_q + 16'd1;
    end
  end

  // Payload FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= bus.rx_byte;
  end

  assign bus.prefix          = pfx_q;
  assign bus.length          = len_q;
  assign bus.interest_packet = ip_q;
  assign bus.prefix_valid    = pv_q;
  assign bus.pay_valid       = cnt_q != '0;
  assign bus.pay_data        = bus.pay_valid ? mem[rd_q] : 8'h00;
  assign bus.err             = err_q;
  assign bus.err_code        = code_q;
  assign bus.pkt_count       = pkt_q;
endmodule

// File: tb/tb_ndn_packet_parser.sv
// Directed bench for ndn_packet_parser.
// Hand-computed vectors, one checking task.
module tb_ndn_packet_parser;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  ndn_packet_parser_if #(.PREFIX_W(64), .LEN_W(6)) bus ();

  ndn_packet_parser #(
    .PREFIX_W(64), .LEN_W(6), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_err = 0;
  int          pv_cyc = 0;
  int          n_hs = 0;
  int          frozen_bad = 0;
  logic [63:0] hs_pfx = '0;
  logic [5:0]  hs_len = '0;
  logic        hs_ip = 1'b0;
  logic        pv_prev = 1'b0;
  logic [63:0] prev_pfx = '0;
  logic [5:0]  prev_len = '0;
  logic        prev_ip = 1'b0;
  logic [7:0]  popped [$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Observe pulses, handshakes, field stability and pops
  always @(posedge clk) begin
    if (bus.err) n_err++;
    if (bus.prefix_valid) pv_cyc++;
    if (pv_prev && bus.prefix_valid &&
        (bus.prefix !== prev_pfx ||
         bus.length !== prev_len ||
         bus.interest_packet !== prev_ip))
      frozen_bad++;
    if (bus.prefix_valid && bus.prefix_ready) begin
      n_hs++;
      hs_pfx = bus.prefix;
      hs_len = bus.length;
      hs_ip  = bus.interest_packet;
    end
    pv_prev  = bus.prefix_valid && !bus.prefix_ready;
    prev_pfx = bus.prefix;
    prev_len = bus.length;
    prev_ip  = bus.interest_packet;
    if (bus.pay_valid && bus.pay_ready)
      popped.push_back(bus.pay_data);
  end

  task automatic send(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    bus.cs       = 1'b0;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_pfx(input logic [63:0] p);
    for (int i = 7; i >= 0; i--) send(p[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic end_frame();
    bus.cs = 1'b1;
    idle(3);
  endtask

  int e0, h0, p0;

  initial begin
    bus.rx_byte      = 8'h00;
    bus.rx_valid     = 1'b0;
    bus.cs           = 1'b1;
    bus.prefix_ready = 1'b1;
    bus.pay_ready    = 1'b1;
    idle(2);
    chk("rst_pv", bus.prefix_valid, 0);
    chk("rst_payv", bus.pay_valid, 0);
    chk("rst_err", {bus.err, bus.err_code}, 0);
    chk("rst_cnt", bus.pkt_count, 0);
    chk("rst_pfx", bus.prefix, 0);
    rst = 1'b1;
    idle(2);

    // 1: interest, len 0
    send(8'h05); send(8'h00);
    send_pfx(64'h1122334455667788);
    idle(4);
    chk("t1_pfx", hs_pfx, 64'h1122334455667788);
    chk("t1_ip", hs_ip, 1);
    chk("t1_len", hs_len, 0);
    chk("t1_pvcyc", pv_cyc, 1);
    chk("t1_cnt", bus.pkt_count, 1);
    chk("t1_payv", bus.pay_valid, 0);
    end_frame();

    // 2: data, 3 payload bytes, drained live
    popped.delete();
    send(8'h06); send(8'h03);
    send_pfx(64'h0102030405060708);
    send(8'hAA); send(8'hBB); send(8'hCC);
    idle(4);
    chk("t2_ip", hs_ip, 0);
    chk("t2_len", hs_len, 3);
    chk("t2_pfx", hs_pfx, 64'h0102030405060708);
    chk("t2_npop", popped.size(), 3);
    chk("t2_pay",
        {popped[0], popped[1], popped[2]}, 24'hAABBCC);
    chk("t2_cnt", bus.pkt_count, 2);
    end_frame();

    // 3: bad type, rest of frame ignored
    e0 = n_err; h0 = n_hs;
    send(8'h07); send(8'h05); send(8'h00);
    send_pfx(64'hDEADBEEFDEADBEEF);
    idle(2);
    chk("t3_nerr", n_err - e0, 1);
    chk("t3_code", bus.err_code, 1);
    chk("t3_nohs", n_hs - h0, 0);
    end_frame();
    send(8'h05); send(8'h00);
    send_pfx(64'hCAFEF00D12345678);
    idle(3);
    chk("t3_next", hs_pfx, 64'hCAFEF00D12345678);
    chk("t3_cnt", bus.pkt_count, 3);
    end_frame();

    // 4: cs rises after 5 prefix bytes
    e0 = n_err; p0 = pv_cyc;
    send(8'h06); send(8'h02);
    for (int i = 1; i <= 5; i++) send(8'(i));
    end_frame();
    chk("t4_nerr", n_err - e0, 1);
    chk("t4_code", bus.err_code, 3);
    chk("t4_nopv", pv_cyc - p0, 0);
    send(8'h05); send(8'h00);
    send_pfx(64'h0F0E0D0C0B0A0908);
    idle(3);
    chk("t4_idle", hs_pfx, 64'h0F0E0D0C0B0A0908);
    chk("t4_cnt", bus.pkt_count, 4);
    end_frame();

    // 5: 20-byte payload into a 16-entry FIFO
    bus.pay_ready = 1'b0;
    popped.delete();
    e0 = n_err; h0 = n_hs;
    send(8'h06); send(8'h14);
    send_pfx(64'h5555AAAA5555AAAA);
    for (int i = 0; i < 20; i++) send(8'(i));
    idle(1);
    chk("t5_nerr", n_err - e0, 1);
    chk("t5_code", bus.err_code, 5);
    chk("t5_hs", n_hs - h0, 1);
    end_frame();
    chk("t5_cnt", bus.pkt_count, 4);
    bus.pay_ready = 1'b1;
    idle(20);
    chk("t5_npop", popped.size(), 16);
    chk("t5_first", popped[0], 8'h00);
    chk("t5_last", popped[15], 8'h0F);
    chk("t5_empty", bus.pay_valid, 0);

    // 6: prefix_ready low, fields frozen, err 4 in HOLD
    bus.pay_ready    = 1'b0;
    bus.prefix_ready = 1'b0;
    frozen_bad = 0;
    e0 = n_err; p0 = pv_cyc;
    send(8'h05); send(8'h04);
    send_pfx(64'h8877665544332211);
    send(8'h01); send(8'h02);
    send(8'h03); send(8'h04);
    send(8'h99);
    idle(5);
    chk("t6_pv", bus.prefix_valid, 1);
    chk("t6_pfx", bus.prefix, 64'h8877665544332211);
    chk("t6_len", bus.length, 4);
    chk("t6_ip", bus.interest_packet, 1);
    chk("t6_frozen", frozen_bad, 0);
    chk("t6_payh", {bus.pay_valid, bus.pay_data}, 9'h101);
    chk("t6_code4", bus.err_code, 4);
    chk("t6_nerr", n_err - e0, 1);
    chk("t6_wait", bus.pkt_count, 4);
    bus.prefix_ready = 1'b1;
    idle(3);
    chk("t6_done", bus.pkt_count, 5);
    chk("t6_pvlo", bus.prefix_valid, 0);
    chk("t6_pvcyc", pv_cyc - p0, 11);
    end_frame();

    // async reset mid-frame
    send(8'h06); send(8'h05);
    send_pfx(64'h1111111111111111);
    send(8'h77);
    #2 rst = 1'b0;
    #1;
    chk("rst_pv2", bus.prefix_valid, 0);
    chk("rst_payv2", bus.pay_valid, 0);
    chk("rst_cnt2", bus.pkt_count, 0);
    chk("rst_pfx2", bus.prefix, 0);
    chk("rst_code2", bus.err_code, 0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
